// File: rtl/mips32_pkg.sv
// Shared types for the MIPS32 memory arbiter: FSM states, port-owner encoding
// and default address/data widths.
package mips32_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  localparam int DEF_AW = 11;
  localparam int DEF_DW = 32;

endpackage

// File: rtl/mips32_starve_ctr.sv
// Saturating count of data grants issued while a fetch was left waiting;
// at_max tells the arbiter to hand the next slot to the fetch port.
module mips32_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk1,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] cnt;

  // Clear takes priority so a fetch grant always restarts the window.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CW'(STARVE_MAX))) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign at_max = (cnt == CW'(STARVE_MAX));

endmodule

// File: rtl/mips32_mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and the data port.
// Data has priority; the starvation counter forces a fetch slot periodically.
module mips32_mem_arbiter
  import mips32_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk1,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          flush,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int LW = $clog2(MEM_LAT + 1);

  state_t        state, state_nx;
  owner_t        owner, owner_nx;
  logic          wr, wr_nx;
  logic          cancel, cancel_nx;
  logic [LW-1:0] lat, lat_nx;

  logic          if_gnt_nx, d_gnt_nx, if_rvalid_nx, d_rvalid_nx;
  logic          mem_en_nx, mem_we_nx;
  logic [AW-1:0] mem_addr_nx;
  logic [DW-1:0] mem_wdata_nx, if_rdata_nx, d_rdata_nx;
  logic          starve_inc, starve_clr, at_max, pick_if;

  mips32_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk1   (clk1),
    .rst_n  (rst_n),
    .inc    (starve_inc),
    .clr    (starve_clr),
    .at_max (at_max)
  );

  // Next-state, grant and response decode; every output is registered below.
  always_comb begin
    state_nx     = state;
    owner_nx     = owner;
    wr_nx        = wr;
    cancel_nx    = cancel;
    lat_nx       = lat;
    if_gnt_nx    = 1'b0;
    d_gnt_nx     = 1'b0;
    if_rvalid_nx = 1'b0;
    d_rvalid_nx  = 1'b0;
    mem_en_nx    = 1'b0;
    mem_we_nx    = 1'b0;
    mem_addr_nx  = '0;
    mem_wdata_nx = '0;
    if_rdata_nx  = if_rdata;
    d_rdata_nx   = d_rdata;
    starve_inc   = 1'b0;
    starve_clr   = 1'b0;
    pick_if      = if_req && (!d_req || at_max);
    case (state)
      IDLE: begin
        starve_clr = !if_req;
        if (if_req || d_req) begin
          state_nx  = WAIT;
          lat_nx    = LW'(MEM_LAT);
          cancel_nx = 1'b0;
          mem_en_nx = 1'b1;
          if (pick_if) begin
            owner_nx    = OWN_IF;
            wr_nx       = 1'b0;
            if_gnt_nx   = 1'b1;
            mem_addr_nx = if_addr;
            starve_clr  = 1'b1;
          end else begin
            owner_nx     = OWN_D;
            wr_nx        = d_we;
            d_gnt_nx     = 1'b1;
            mem_we_nx    = d_we;
            mem_addr_nx  = d_addr;
            mem_wdata_nx = d_wdata;
            starve_inc   = if_req;
          end
        end
      end
      WAIT: begin
        if ((owner == OWN_IF) && flush) begin
          cancel_nx = 1'b1;
        end
        if (lat == '0) begin
          state_nx  = IDLE;
          cancel_nx = 1'b0;
          if (owner == OWN_IF) begin
            // A flush on the final cycle still cancels the response.
            if (!(cancel || flush)) begin
              if_rvalid_nx = 1'b1;
              if_rdata_nx  = mem_rdata;
            end
          end else begin
            d_rvalid_nx = 1'b1;
            d_rdata_nx  = wr ? '0 : mem_rdata;
          end
        end else begin
          lat_nx = lat - LW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      wr        <= 1'b0;
      cancel    <= 1'b0;
      lat       <= '0;
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_nx;
      owner     <= owner_nx;
      wr        <= wr_nx;
      cancel    <= cancel_nx;
      lat       <= lat_nx;
      if_gnt    <= if_gnt_nx;
      d_gnt     <= d_gnt_nx;
      if_rvalid <= if_rvalid_nx;
      d_rvalid  <= d_rvalid_nx;
      if_rdata  <= if_rdata_nx;
      d_rdata   <= d_rdata_nx;
      mem_en    <= mem_en_nx;
      mem_we    <= mem_we_nx;
      mem_addr  <= mem_addr_nx;
      mem_wdata <= mem_wdata_nx;
    end
  end

  assign busy = (state == WAIT);

endmodule
